// File: rtl/sdr_lb_pkg.sv
// Shared types and constants for the SDR SDRAM local-bus initiator.
package sdr_lb_pkg;

    localparam int MAX_BURST = 8;
    localparam int LEN_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } lb_state_e;

    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(MAX_BURST));
    endfunction

endpackage

// File: rtl/sdr_lb_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a bulk-discard input.
module sdr_lb_fifo #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    input  logic [AW:0]   skip_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;
    logic [CW-1:0] adv;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    // skip_i discards several head words at once; caller never asks for more than count_o
    assign adv     = pop_ok ? CW'(1) : skip_i;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            rptr_q  <= rptr_q + adv[AW-1:0];
            count_q <= count_q + CW'(push_ok) - adv;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sdr_lb_initiator.sv
// Local-bus initiator for the SDR SDRAM controller: host burst commands in, RADDR/R_REQ/W_REQ out.
// Define SDR_LB_TIMEOUT_EN to add a watchdog that aborts a stalled burst and flags ERR.
module sdr_lb_initiator
    import sdr_lb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SDRAM_RASIZE = 31,
    parameter int FIFO_AW      = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WRITE,
    input  logic [SDRAM_RASIZE-1:0] CMD_ADDR,
    input  logic [3:0]              CMD_LEN,
    input  logic                    CMD_APCH,
    input  logic                    WD_VALID,
    output logic                    WD_READY,
    input  logic [DATA_WIDTH-1:0]   WD_DATA,
    output logic                    RD_VALID,
    input  logic                    RD_READY,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic                    BUSY,
    output logic                    ERR,
    output logic [SDRAM_RASIZE-1:0] RADDR,
    output logic                    R_REQ,
    output logic                    W_REQ,
    output logic [3:0]              B_SIZE,
    output logic                    AUTO_PCH,
    input  logic                    RW_ACK,
    input  logic                    D_REQ,
    input  logic                    R_VALID,
    input  logic                    W_VALID,
    output logic [DATA_WIDTH-1:0]   LB_WDATA,
    input  logic [DATA_WIDTH-1:0]   LB_RDATA
);

    localparam int CW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    lb_state_e                state_q, state_d;
    logic [SDRAM_RASIZE-1:0]  raddr_q, raddr_d;
    logic [LEN_W-1:0]         bsize_q, bsize_d, cnt_q, cnt_d;
    logic                     apch_q, apch_d, wr_q, wr_d;
    logic                     wreq_q, wreq_d, rreq_q, rreq_d;
    logic                     err_q, err_d, rdy_q;
    logic [DATA_WIDTH-1:0]    lbw_q, lbw_d;

    logic                     wf_pop, wf_full, wf_empty;
    logic [DATA_WIDTH-1:0]    wf_rdata;
    logic [CW-1:0]            wf_count, wf_skip;
    logic                     rf_push, rf_full, rf_empty;
    logic [DATA_WIDTH-1:0]    rf_rdata;
    logic [CW-1:0]            rf_count, rf_free;

    logic cmd_legal, cmd_fits, accept, beat;
    logic unused_ok;

    sdr_lb_fifo #(.DW(DATA_WIDTH), .AW(FIFO_AW)) u_wfifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (WD_VALID & rdy_q),
        .wdata_i (WD_DATA),
        .pop_i   (wf_pop),
        .skip_i  (wf_skip),
        .full_o  (wf_full),
        .empty_o (wf_empty),
        .rdata_o (wf_rdata),
        .count_o (wf_count)
    );

    sdr_lb_fifo #(.DW(DATA_WIDTH), .AW(FIFO_AW)) u_rfifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (rf_push),
        .wdata_i (LB_RDATA),
        .pop_i   (RD_READY),
        .skip_i  ('0),
        .full_o  (rf_full),
        .empty_o (rf_empty),
        .rdata_o (rf_rdata),
        .count_o (rf_count)
    );

    // Read space is reserved at accept; only the host pops, so the reservation can only grow.
    assign rf_free   = CW'(DEPTH) - rf_count;
    assign cmd_legal = len_legal(CMD_LEN);
    assign cmd_fits  = CMD_WRITE ? (wf_count >= CW'(CMD_LEN)) : (rf_free >= CW'(CMD_LEN));
    assign CMD_READY = rdy_q && (state_q == IDLE) && (!cmd_legal || cmd_fits);
    assign accept    = CMD_VALID && CMD_READY;
    assign beat      = wr_q ? D_REQ : R_VALID;

`ifdef SDR_LB_TIMEOUT_EN
    localparam int WDW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    logic [WDW-1:0] wdog_q;
    logic           activity, timeout;

    assign activity = RW_ACK | D_REQ | R_VALID;
    assign timeout  = (state_q != IDLE) && !activity && (wdog_q == WDW'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                                              wdog_q <= '0;
        else if (state_q == IDLE || activity || state_d != state_q) wdog_q <= '0;
        else                                                    wdog_q <= wdog_q + 1'b1;
    end

    assign unused_ok = ^{W_VALID, wf_empty, rf_full};
`else
    assign unused_ok = ^{W_VALID, wf_empty, rf_full, (TIMEOUT != 0)};
`endif

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        bsize_d = bsize_q;
        apch_d  = apch_q;
        wr_d    = wr_q;
        wreq_d  = wreq_q;
        rreq_d  = rreq_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        lbw_d   = lbw_q;
        wf_pop  = 1'b0;
        wf_skip = '0;
        rf_push = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_legal) begin
                        raddr_d = CMD_ADDR;
                        bsize_d = CMD_LEN;
                        apch_d  = CMD_APCH;
                        wr_d    = CMD_WRITE;
                        wreq_d  = CMD_WRITE;
                        rreq_d  = !CMD_WRITE;
                        state_d = REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (RW_ACK) begin
                    wreq_d = 1'b0;
                    rreq_d = 1'b0;
                    // a data beat coincident with the ack is the first beat of the burst
                    if (beat) begin
                        wf_pop  = wr_q;
                        rf_push = !wr_q;
                        if (wr_q) lbw_d = wf_rdata;
                        cnt_d   = bsize_q - 1'b1;
                        state_d = (bsize_q == LEN_W'(1)) ? IDLE : (wr_q ? WDATA : RDATA);
                    end else begin
                        cnt_d   = bsize_q;
                        state_d = wr_q ? WDATA : RDATA;
                    end
                end
            end
            WDATA, RDATA: begin
                if (beat) begin
                    wf_pop  = wr_q;
                    rf_push = !wr_q;
                    if (wr_q) lbw_d = wf_rdata;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SDR_LB_TIMEOUT_EN
        if (timeout) begin
            wreq_d  = 1'b0;
            rreq_d  = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
            // discard the write words this burst would have consumed; read beats already stored stay
            if (wr_q) wf_skip = CW'((state_q == REQ) ? bsize_q : cnt_q);
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            raddr_q <= '0;
            bsize_q <= '0;
            apch_q  <= 1'b0;
            wr_q    <= 1'b0;
            wreq_q  <= 1'b0;
            rreq_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            lbw_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            bsize_q <= bsize_d;
            apch_q  <= apch_d;
            wr_q    <= wr_d;
            wreq_q  <= wreq_d;
            rreq_q  <= rreq_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            lbw_q   <= lbw_d;
            rdy_q   <= 1'b1;
        end
    end

    assign WD_READY = rdy_q & ~wf_full;
    assign RD_VALID = ~rf_empty;
    assign RD_DATA  = rf_empty ? '0 : rf_rdata;
    assign BUSY     = (state_q != IDLE);
    assign ERR      = err_q;
    assign RADDR    = raddr_q;
    assign R_REQ    = rreq_q;
    assign W_REQ    = wreq_q;
    assign B_SIZE   = bsize_q;
    assign AUTO_PCH = apch_q;
    assign LB_WDATA = lbw_q;

endmodule
